// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and helpers for the instruction-fetch front
//               end. It holds the condition-code encodings, the HLT opcode,
//               the flag bit positions and the branch-condition evaluator.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam logic [2:0] COND_NE = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_GT = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_GE = 3'b100;
  localparam logic [2:0] COND_LE = 3'b101;
  localparam logic [2:0] COND_OV = 3'b110;
  localparam logic [2:0] COND_UN = 3'b111;

  localparam logic [3:0] OPC_HLT = 4'hF;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  // Returns 1 when the branch condition holds for the given {Z,V,N} flags.
  function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] fl);
    logic z;
    logic v;
    logic n;
    logic met;
    z = fl[FLAG_Z];
    v = fl[FLAG_V];
    n = fl[FLAG_N];
    case (cond)
      COND_NE: met = !z;
      COND_EQ: met = z;
      COND_GT: met = !z && !n;
      COND_LT: met = n;
      COND_GE: met = z || (!z && !n);
      COND_LE: met = z || n;
      COND_OV: met = v;
      default: met = 1'b1;
    endcase
    return met;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_if
// Description : Instruction-memory bus between the fetch unit and memory.
//               Requests use a valid/ready handshake; responses return in
//               request order with a valid strobe and no back-pressure.
// Modports    : master - fetch unit side (drives requests, receives data)
//               slave  - memory side (accepts requests, returns data)
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic               mem_rsp_valid;
  logic [INSTR_W-1:0] mem_rsp_data;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous FIFO holding {pc, instr} entries between memory
//               and decode. Push and pop may occur in the same cycle; flush
//               empties the queue and overrides both.
// Ports       : clk, rst_n        - clock, async active-low reset
//               push, push_data   - write strobe and entry
//               pop               - read strobe (head advances)
//               flush             - discard all entries
//               pop_data, empty   - head entry and empty flag
//               count             - number of valid entries (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch front end. Issues pipelined requests to a
//               variable-latency memory, queues returned words with their PC,
//               resolves B/BR redirects and stops fetching after HLT.
// Ports       : clk, rst_n              - clock, async active-low reset
//               mem (fetch_if.master)   - instruction-memory bus
//               instr_valid/ready/data/pc - decode-side queue head
//               br_*, flags             - branch from decode and ALU flags
//               pc                      - next fetch address
//               halted                  - HLT consumed, fetch stopped
// Options     : FETCH_PERF_CNT_EN adds saturating perf_fetch_cnt,
//               perf_redirect_cnt and perf_stall_cnt outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W          = 16,
  parameter int                INSTR_W         = 16,
  parameter int                DEPTH           = 4,
  parameter int                MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_PC        = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_if.master            mem,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               br_valid,
  input  logic               br_type,
  input  logic [2:0]         br_cond,
  input  logic [8:0]         br_imm,
  input  logic [ADDR_W-1:0]  br_reg,
  input  logic [ADDR_W-1:0]  br_pc,
  input  logic [2:0]         flags,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_redirect_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int QW    = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;   // PC of the next kept response
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  drop_q, drop_d;       // stale responses still to discard
  logic              halted_q, halted_d;

  logic [CNT_W-1:0]  q_count;
  logic              q_empty;
  logic [QW-1:0]     q_head;
  logic [CNT_W:0]    occupancy;
  logic              req_valid, accept, taken, push, pop, head_valid;
  logic [ADDR_W-1:0] imm_sext, target;

  always_comb begin
    // Queue slots already promised to in-flight requests count as occupied,
    // which is what keeps the queue from ever overflowing. rst_n gates the
    // request so the bus stays idle while reset is held.
    occupancy  = {1'b0, q_count} + {1'b0, inflight_q};
    req_valid  = rst_n && !halted_q
                 && (inflight_q < CNT_W'(MAX_OUTSTANDING))
                 && (occupancy < (CNT_W + 1)'(DEPTH));
    accept     = req_valid && mem.mem_req_ready;

    taken      = br_valid && cond_met(br_cond, flags);
    imm_sext   = {{(ADDR_W - 9){br_imm[8]}}, br_imm};
    target     = br_type ? br_reg : (br_pc + ADDR_W'(2) + (imm_sext << 1));

    head_valid = !q_empty && !halted_q;
    pop        = head_valid && instr_ready && !taken;
    push       = mem.mem_rsp_valid && (drop_q == '0) && !taken;

    inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(mem.mem_rsp_valid);

    // Everything still outstanding after this cycle belongs to the old path.
    drop_d = drop_q;
    if (taken) begin
      drop_d = inflight_d;
    end else if (mem.mem_rsp_valid && (drop_q != '0)) begin
      drop_d = drop_q - CNT_W'(1);
    end

    rsp_pc_d = rsp_pc_q;
    if (taken) begin
      rsp_pc_d = target;
    end else if (push) begin
      rsp_pc_d = rsp_pc_q + ADDR_W'(2);
    end

    pc_d = pc_q;
    if (taken) begin
      pc_d = target;
    end else if (accept) begin
      pc_d = pc_q + ADDR_W'(2);
    end

    halted_d = halted_q;
    if (taken) begin
      halted_d = 1'b0;
    end else if (pop && (q_head[INSTR_W-1 -: 4] == OPC_HLT)) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      halted_q   <= halted_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (QW)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({rsp_pc_q, mem.mem_rsp_data}),
    .pop       (pop),
    .flush     (taken),
    .pop_data  (q_head),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign mem.mem_req_valid = req_valid;
  assign mem.mem_req_addr  = pc_q;
  assign instr_valid       = head_valid;
  assign instr_data        = q_head[INSTR_W-1:0];
  assign instr_pc          = q_head[QW-1:INSTR_W];
  assign pc                = pc_q;
  assign halted            = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d    = fetch_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if (accept && (fetch_cnt_q != '1))       fetch_cnt_d    = fetch_cnt_q + 32'd1;
    if (taken && (redirect_cnt_q != '1))     redirect_cnt_d = redirect_cnt_q + 32'd1;
    if (!halted_q && !req_valid && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      fetch_cnt_q    <= fetch_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt    = fetch_cnt_q;
  assign perf_redirect_cnt = redirect_cnt_q;
  assign perf_stall_cnt    = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with an in-order
//               1-cycle-latency instruction memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_if #(.ADDR_W(16), .INSTR_W(16)) mif ();

  logic        instr_valid, instr_ready;
  logic [15:0] instr_data, instr_pc;
  logic        br_valid, br_type;
  logic [2:0]  br_cond, flags;
  logic [8:0]  br_imm;
  logic [15:0] br_reg, br_pc, pc;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_redirect_cnt, perf_stall_cnt;
`endif

  fetch_unit #(
    .ADDR_W(16), .INSTR_W(16), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(16'h0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem         (mif),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc),
    .br_valid    (br_valid),
    .br_type     (br_type),
    .br_cond     (br_cond),
    .br_imm      (br_imm),
    .br_reg      (br_reg),
    .br_pc       (br_pc),
    .flags       (flags),
    .pc          (pc),
    .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_redirect_cnt (perf_redirect_cnt),
    .perf_stall_cnt    (perf_stall_cnt)
`endif
  );

  int          tests = 0;
  int          fails = 0;
  logic [15:0] hlt_addr = 16'hFFFF;
  bit          mem_stall = 1'b0;
  logic [15:0] pend[$];
  logic [15:0] got_pc[$];
  logic [15:0] got_data[$];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == hlt_addr) ? 16'hF000 : {4'h1, a[11:0]};
  endfunction

  // Memory: a request accepted at edge k is answered at edge k+1, in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete();
      mif.mem_rsp_valid = 1'b0;
      mif.mem_rsp_data  = 16'h0000;
    end else begin
      if (mif.mem_rsp_valid) void'(pend.pop_front());
      if (!mem_stall && pend.size() > 0) begin
        mif.mem_rsp_valid = 1'b1;
        mif.mem_rsp_data  = mem_word(pend[0]);
      end else begin
        mif.mem_rsp_valid = 1'b0;
      end
      if (mif.mem_req_valid && mif.mem_req_ready) pend.push_back(mif.mem_req_addr);
    end
  end

  task automatic tick();
    if (instr_valid && instr_ready) begin
      got_pc.push_back(instr_pc);
      got_data.push_back(instr_data);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    mem_stall   = 1'b0;
    br_valid    = 1'b0;
    instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    got_pc.delete();
    got_data.delete();
  endtask

  task automatic pulse_branch(input logic t, input logic [2:0] c, input logic [2:0] f,
                              input logic [15:0] bpc, input logic [8:0] imm, input logic [15:0] r);
    br_type = t; br_cond = c; flags = f; br_pc = bpc; br_imm = imm; br_reg = r;
    br_valid = 1'b1;
    tick();
    br_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (pc !== 16'h0000) begin fails++; $display("FAIL reset_pc: got %h want %h", pc, 16'h0000); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
    tests++; if (mif.mem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b want 0", mif.mem_req_valid); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b want 0", halted); end
    do_reset();
    tests++; if (mif.mem_req_valid !== 1'b1 || mif.mem_req_addr !== 16'h0000) begin
      fails++; $display("FAIL first_req: got v=%b a=%h want v=1 a=0000", mif.mem_req_valid, mif.mem_req_addr);
    end
  endtask

  task automatic test_streaming();
    int drops = 0;
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (!mif.mem_req_valid) drops++;
    end
    tests++; if (drops != 0) begin fails++; $display("FAIL stream_req_drops: got %0d want 0", drops); end
    tests++; if (got_pc.size() != 23) begin fails++; $display("FAIL stream_pop_count: got %0d want 23", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++) begin
      tests++;
      if (got_pc[i] !== 16'(2 * i) || got_data[i] !== mem_word(16'(2 * i))) begin
        fails++; $display("FAIL stream_entry[%0d]: got pc=%h d=%h want pc=%h d=%h",
                          i, got_pc[i], got_data[i], 16'(2 * i), mem_word(16'(2 * i)));
      end
    end
  endtask

  task automatic test_backpressure();
    bit saw_block = 1'b0;
    instr_ready = 1'b0;
    got_pc.delete(); got_data.delete();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!mif.mem_req_valid) saw_block = 1'b1;
    end
    tests++; if (!saw_block || mif.mem_req_valid !== 1'b0) begin
      fails++; $display("FAIL bp_req_blocked: got seen=%b valid=%b want seen=1 valid=0", saw_block, mif.mem_req_valid);
    end
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 16'h002E) begin
      fails++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=002e", instr_valid, instr_pc);
    end
    instr_ready = 1'b1;
    repeat (12) tick();
    tests++; if (got_pc.size() != 12) begin fails++; $display("FAIL bp_pop_count: got %0d want 12", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++) begin
      tests++;
      if (got_pc[i] !== 16'(16'h002E + 2 * i) || got_data[i] !== mem_word(16'(16'h002E + 2 * i))) begin
        fails++; $display("FAIL bp_entry[%0d]: got pc=%h d=%h want pc=%h", i, got_pc[i], got_data[i], 16'(16'h002E + 2 * i));
      end
    end
  endtask

  task automatic test_redirect_b();
    do_reset();
    instr_ready = 1'b1;
    mem_stall   = 1'b1;
    repeat (4) tick();
    tests++; if (mif.mem_req_valid !== 1'b0 || pc !== 16'h0004) begin
      fails++; $display("FAIL b_setup: got v=%b pc=%h want v=0 pc=0004", mif.mem_req_valid, pc);
    end
    pulse_branch(1'b0, COND_UN, 3'b000, 16'h0010, 9'h1FE, 16'h0000);
    tests++; if (pc !== 16'h000E) begin fails++; $display("FAIL b_target: got %h want 000e", pc); end
    mem_stall = 1'b0;
    got_pc.delete(); got_data.delete();
    repeat (8) tick();
    tests++;
    if (got_pc.size() < 2) begin
      fails++; $display("FAIL b_resume_count: got %0d want >=2", got_pc.size());
    end else if (got_pc[0] !== 16'h000E || got_pc[1] !== 16'h0010 || got_data[0] !== mem_word(16'h000E)) begin
      fails++; $display("FAIL b_resume: got pc0=%h pc1=%h d0=%h want 000e 0010 %h",
                        got_pc[0], got_pc[1], got_data[0], mem_word(16'h000E));
    end
  endtask

  task automatic test_cond_branches();
    logic        t_typ [10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    logic [2:0]  t_cond[10] = '{COND_EQ, COND_EQ, COND_LE, COND_UN, COND_GT,
                                COND_NE, COND_OV, COND_GE, COND_LT, COND_UN};
    logic [2:0]  t_flg [10] = '{3'b000, 3'b100, 3'b001, 3'b000, 3'b001,
                                3'b100, 3'b010, 3'b000, 3'b000, 3'b000};
    logic [15:0] t_bpc [10] = '{16'h0020, 16'h0020, 16'h0040, 16'h0000, 16'h0080,
                                16'h0080, 16'h0000, 16'h0300, 16'h0300, 16'h0000};
    logic [8:0]  t_imm [10] = '{9'h004, 9'h004, 9'h000, 9'h000, 9'h010,
                                9'h010, 9'h000, 9'h1F0, 9'h1F0, 9'h000};
    logic [15:0] t_reg [10] = '{16'h0, 16'h0, 16'h0, 16'h1234, 16'h0,
                                16'h0, 16'h0300, 16'h0, 16'h0, 16'h1234};
    logic [15:0] t_exp [10] = '{16'h0004, 16'h002A, 16'h0042, 16'h1234, 16'h1234,
                                16'h1234, 16'h0300, 16'h02E2, 16'h02E2, 16'h1234};
    do_reset();
    instr_ready = 1'b1;
    mem_stall   = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 10; i++) begin
      pulse_branch(t_typ[i], t_cond[i], t_flg[i], t_bpc[i], t_imm[i], t_reg[i]);
      tests++; if (pc !== t_exp[i]) begin fails++; $display("FAIL cond_branch[%0d]: got pc=%h want %h", i, pc, t_exp[i]); end
      tick();
    end
    mem_stall = 1'b0;
    got_pc.delete(); got_data.delete();
    repeat (8) tick();
    tests++; if (got_pc.size() < 1 || got_pc[0] !== 16'h1234) begin
      fails++; $display("FAIL cond_resume: got n=%0d pc0=%h want pc0=1234", got_pc.size(),
                        (got_pc.size() > 0) ? got_pc[0] : 16'hxxxx);
    end
  endtask

  task automatic test_halt();
    bit found = 1'b0;
    int bad = 0;
    hlt_addr = 16'h0006;
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 30 && !found; i++) begin
      if (instr_valid && instr_pc === 16'h0006) begin
        found = 1'b1;
        tests++; if (instr_data !== 16'hF000) begin fails++; $display("FAIL hlt_word: got %h want f000", instr_data); end
      end
      tick();
    end
    tests++; if (!found) begin fails++; $display("FAIL hlt_seen: got 0 want 1"); end
    tests++; if (halted !== 1'b1 || mif.mem_req_valid !== 1'b0) begin
      fails++; $display("FAIL hlt_next: got halted=%b req=%b want 1 0", halted, mif.mem_req_valid);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mif.mem_req_valid || instr_valid || !halted) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL hlt_hold: got %0d bad cycles want 0", bad); end
    got_pc.delete(); got_data.delete();
    pulse_branch(1'b1, COND_UN, 3'b000, 16'h0000, 9'h000, 16'h0100);
    tests++; if (halted !== 1'b0 || pc !== 16'h0100) begin
      fails++; $display("FAIL hlt_redirect: got halted=%b pc=%h want 0 0100", halted, pc);
    end
    repeat (6) tick();
    tests++; if (got_pc.size() < 1 || got_pc[0] !== 16'h0100) begin
      fails++; $display("FAIL hlt_resume: got n=%0d pc0=%h want pc0=0100", got_pc.size(),
                        (got_pc.size() > 0) ? got_pc[0] : 16'hxxxx);
    end
    hlt_addr = 16'hFFFF;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    instr_ready = 1'b1;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    tests++; if (pc !== 16'h0000 || instr_valid !== 1'b0 || mif.mem_req_valid !== 1'b0 || halted !== 1'b0) begin
      fails++; $display("FAIL midreset_state: got pc=%h iv=%b rv=%b h=%b want 0000 0 0 0",
                        pc, instr_valid, mif.mem_req_valid, halted);
    end
    do_reset();
    instr_ready = 1'b1;
    repeat (6) tick();
    tests++; if (got_pc.size() != 4) begin fails++; $display("FAIL midreset_count: got %0d want 4", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++) begin
      tests++; if (got_pc[i] !== 16'(2 * i)) begin
        fails++; $display("FAIL midreset_entry[%0d]: got %h want %h", i, got_pc[i], 16'(2 * i));
      end
    end
  endtask

  initial begin
    mif.mem_req_ready = 1'b1;
    mif.mem_rsp_valid = 1'b0;
    mif.mem_rsp_data  = 16'h0000;
    instr_ready = 1'b0;
    br_valid = 1'b0; br_type = 1'b0; br_cond = 3'b000; br_imm = 9'h000;
    br_reg = 16'h0000; br_pc = 16'h0000; flags = 3'b000;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_b();
    test_cond_branches();
    test_halt();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the 16-bit ISA.
- Replaces the fixed PC register plus PC-control pair with one block that does all of the following:
  - issues pipelined requests to a variable-latency instruction memory;
  - buffers returned instructions with their PC in a queue;
  - resolves B/BR redirects from the 3-bit condition code and flags;
  - stops fetching on HLT.
- Sits between instruction memory and decode.

Parameters:
- ADDR_W, 16, PC and memory address width in bits (byte addresses).
- INSTR_W, 16, instruction width.
- DEPTH, 4, instruction queue entries (power of two, >=2).
- MAX_OUTSTANDING, 2, maximum memory requests in flight (<= DEPTH).
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_req_valid  out  1  fetch request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  fetch byte address
- mem_rsp_valid  in  1  response valid; responses return in request order
- mem_rsp_data  in  INSTR_W  instruction word
- instr_valid  out  1  queue head valid
- instr_ready  in  1  decode consumes head
- instr_data  out  INSTR_W  head instruction
- instr_pc  out  ADDR_W  byte address of head instruction
- br_valid  in  1  branch at decode, one-cycle pulse
- br_type  in  1  0 = B (PC-relative), 1 = BR (register target)
- br_cond  in  3  condition code
- br_imm  in  9  signed word offset
- br_reg  in  ADDR_W  register target
- br_pc  in  ADDR_W  byte address of the branch instruction
- flags  in  3  [2]=Z, [1]=V, [0]=N
- pc  out  ADDR_W  next fetch address
- halted  out  1  HLT consumed, fetch stopped

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; queue empty; inflight=0; drop=0.
  - mem_req_valid=0, instr_valid=0, halted=0.
  - All counters 0.
- Issue and memory handshake:
  - mem_req_valid=1 when all hold: !halted, inflight<MAX_OUTSTANDING, (queue count + inflight)<DEPTH.
  - mem_req_addr=pc.
  - On accept (mem_req_valid & mem_req_ready): pc += 2 (wraps modulo 2^ADDR_W); inflight++.
  - On mem_rsp_valid: inflight--.
    - If drop>0: discard the response and drop--.
    - Otherwise push {mem_rsp_data, address} into the queue. The address comes from an internal response-PC tracker.
  - Queue can never overflow, by construction of the issue rule. A push and a pop in the same cycle are both legal.
- Queue output:
  - instr_valid = queue not empty.
  - Pop on instr_valid & instr_ready.
  - A push into an empty queue is visible on the next cycle (1-cycle latency, memory response to instr_valid).
- Branch resolution (combinational on br_valid):
  - 000 NE: Z==0
  - 001 EQ: Z==1
  - 010 GT: Z==0 & N==0
  - 011 LT: N==1
  - 100 GE: Z==1 | (Z==0 & N==0)
  - 101 LE: Z==1 | N==1
  - 110 OV: V==1
  - 111 UN: always
  - Targets:
    - B target = br_pc + 2 + (sext(br_imm) << 1).
    - BR target = br_reg.
  - Not-taken: no effect.
- Taken redirect (next edge):
  - pc=target; queue flushed.
  - drop = inflight after this cycle's updates, counting both of the following:
    - a request accepted in the same cycle (it is stale);
    - a response arriving in the same cycle (it is discarded and not pushed).
  - halted cleared.
  - A redirect wins over the same-cycle pop.
- Halt:
  - Popping a head whose opcode [15:12]==4'hF sets halted the next cycle. Further issue is blocked.
  - Outstanding responses still arrive and are pushed, but not popped while halted (instr_valid forced 0).
  - Only reset or a taken redirect clears halted.
- Reset mid-transaction: all state clears immediately. Memory is reset by the same rst_n, so no stale responses follow.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt[31:0], perf_redirect_cnt[31:0], perf_stall_cnt[31:0].
  - perf_fetch_cnt: accepted requests.
  - perf_redirect_cnt: taken redirects.
  - perf_stall_cnt: cycles with !halted and mem_req_valid=0.
  - All saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and logic are absent; the block is otherwise identical.

Decomposition:
- fetch_pkg holds:
  - condition-code constants COND_NE..COND_UN;
  - OPC_HLT=4'hF;
  - flag bit indices FLAG_Z=2, FLAG_V=1, FLAG_N=0.
- Sub-module fetch_queue: parametrised synchronous FIFO.
  - Ports: push, pop, flush, count.
  - Payload: {pc, instr}.

Test Plan:
- Streaming, mem_req_ready=1, 1-cycle response latency, instr_ready=1 → instr_pc sequence 0x0000, 0x0002, 0x0004, …; mem_req_valid never drops once steady.
- instr_ready=0 for 10 cycles → mem_req_valid deasserts when count+inflight=4; no response is lost; after release, PCs continue contiguously.
- Taken B at br_pc=0x0010, br_imm=9'h1FE (-2), cond=UN with 2 requests in flight → pc=0x000E; both stale responses discarded; next instr_pc=0x000E.
- Conditional branches:
  - cond=EQ, flags=3'b000 → no redirect.
  - cond=EQ, flags=3'b100 → redirect.
  - cond=LE, flags=3'b001 → redirect.
  - BR with br_reg=0x1234 → pc=0x1234.
- Head instruction 16'hF000 popped → halted=1 next cycle; mem_req_valid stays 0 for 20 cycles.
- rst_n pulsed low mid-burst → immediate pc=RESET_PC, instr_valid=0; fetch restarts at 0x0000.
